// File: rtl/mimc_decipher_seq.sv
// Iterative MiMC-7 decryption engine: one round per pass, 7th root via a
// constant-time square-and-always-multiply ladder on a bit-serial multiplier.
module mimc_decipher_seq #(
    parameter int                 N_BITS   = 254,
    parameter int                 ROUNDS   = 91,
    parameter logic [N_BITS-1:0]  MODULUS  =
        254'd21888242871839275222246405745257275088548364400416034343698204186575808495617,
    parameter int                 EXP_BITS = 254,
    // (p-1) = 5 mod 7, so 4*(p-1)+1 is the multiple of 7 giving 7^-1 mod (p-1)
    parameter logic [EXP_BITS-1:0] INV_EXP =
        EXP_BITS'((260'd4 * (260'(MODULUS) - 260'd1) + 260'd1) / 260'd7)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_BITS-1:0]         ct,
    input  logic [N_BITS-1:0]         key,
    output logic [$clog2(ROUNDS)-1:0] rc_idx,
    input  logic [N_BITS-1:0]         rc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_BITS-1:0]         pt,
    output logic                      err,
    output logic                      busy
);

    localparam int RC_W   = $clog2(ROUNDS);
    localparam int STEP_W = $clog2(N_BITS + 1);
    localparam int EB_W   = $clog2(EXP_BITS);
    localparam logic [N_BITS+1:0] P_W = {2'b00, MODULUS};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXP,
        S_SUB,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [N_BITS-1:0] r_x;
    logic [N_BITS-1:0] r_k;
    logic [N_BITS-1:0] r_y;
    logic [N_BITS-1:0] r_pt;
    logic [N_BITS-1:0] r_ma;
    logic [N_BITS-1:0] r_mb;
    logic [N_BITS-1:0] r_acc;
    logic              r_err;
    logic              r_phase;
    logic [STEP_W-1:0] r_step;
    logic [EB_W-1:0]   r_ebit;
    logic [RC_W-1:0]   r_rnd;

    logic [N_BITS+1:0] w_sum;
    logic [N_BITS+1:0] w_red1;
    logic [N_BITS-1:0] w_red2;
    logic [N_BITS-1:0] w_sub;
    logic              w_mul_last;
    logic              w_exp_last;
    logic              w_bad;

    // (a - b) mod p for canonical a, b: a borrow adds p back once
    function automatic logic [N_BITS-1:0] f_modsub(
        input logic [N_BITS-1:0] a,
        input logic [N_BITS-1:0] b
    );
        logic [N_BITS:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[N_BITS]) begin
            d = d + {1'b0, MODULUS};
        end
        return d[N_BITS-1:0];
    endfunction

    // acc < p and a < p keep 2*acc + a below 3p, so two trims land in [0,p)
    assign w_sum  = {1'b0, r_acc, 1'b0}
                  + (r_mb[N_BITS-1] ? {2'b00, r_ma} : '0);
    assign w_red1 = (w_sum >= P_W) ? (w_sum - P_W) : w_sum;
    assign w_red2 = N_BITS'((w_red1 >= P_W) ? (w_red1 - P_W) : w_red1);

    assign w_mul_last = (r_step == STEP_W'(N_BITS));
    assign w_exp_last = w_mul_last & r_phase & (r_ebit == '0);
    assign w_sub      = f_modsub(f_modsub(r_y, r_k), rc);
    assign w_bad      = (ct >= MODULUS) | (key >= MODULUS);

    assign rc_idx = r_rnd;
    assign pt     = r_pt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        err         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = r_err ? S_DONE : S_EXP;
            end
            S_EXP: begin
                if (w_exp_last) begin
                    w_state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                w_state_nxt = (r_rnd == '0) ? S_DONE : S_EXP;
            end
            S_DONE: begin
                out_valid = 1'b1;
                err       = r_err;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, exponent ladder, bit-serial multiply, rounds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_k     <= '0;
            r_y     <= '0;
            r_pt    <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_phase <= 1'b0;
            r_step  <= '0;
            r_ebit  <= '0;
            r_rnd   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= ct;
                        r_k   <= key;
                        r_err <= w_bad;
                        r_pt  <= '0;
                        r_rnd <= RC_W'(ROUNDS - 1);
                    end
                end
                S_LOAD: begin
                    if (r_err) begin
                        r_rnd <= '0;
                    end else begin
                        r_x     <= f_modsub(r_x, r_k);
                        r_y     <= N_BITS'(1);
                        r_step  <= '0;
                        r_phase <= 1'b0;
                        r_ebit  <= EB_W'(EXP_BITS - 1);
                    end
                end
                S_EXP: begin
                    if (r_step == '0) begin
                        r_ma  <= r_y;
                        r_mb  <= r_phase ? r_x : r_y;
                        r_acc <= '0;
                    end else begin
                        r_acc <= w_red2;
                        r_mb  <= r_mb << 1;
                    end
                    if (w_mul_last) begin
                        r_step  <= '0;
                        r_phase <= ~r_phase;
                        // product always formed; only the commit depends on the bit
                        if (!r_phase || INV_EXP[r_ebit]) begin
                            r_y <= w_red2;
                        end
                        if (r_phase) begin
                            r_ebit <= r_ebit - 1'b1;
                        end
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_SUB: begin
                    r_x <= w_sub;
                    if (r_rnd == '0) begin
                        r_pt <= w_sub;
                    end else begin
                        r_rnd   <= r_rnd - 1'b1;
                        r_y     <= N_BITS'(1);
                        r_step  <= '0;
                        r_phase <= 1'b0;
                        r_ebit  <= EB_W'(EXP_BITS - 1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mimc_decipher_seq.sv
// Bench for mimc_decipher_seq in the small field (p=251, 3 rounds):
// a behavioural MiMC model predicts every output cycle by cycle.
module tb_mimc_decipher_seq;

    localparam int N    = 8;
    localparam int R    = 3;
    localparam int M    = 251;
    localparam int EB   = 8;
    localparam int SUBP = 2 * EB * (N + 1) + 1;
    localparam int LAT  = 1 + R * SUBP;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ct;
    logic [7:0] key;
    logic [1:0] rc_idx;
    logic [7:0] rc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pt;
    logic       err;
    logic       busy;

    int rom [4] = '{0, 10, 20, 0};
    int errors = 0;
    int checks = 0;

    int m_phase = 0;
    int m_k     = 0;
    int m_lat   = 0;
    int m_pt    = 0;
    bit m_err   = 1'b0;

    mimc_decipher_seq #(
        .N_BITS   (N),
        .ROUNDS   (R),
        .MODULUS  (8'd251),
        .EXP_BITS (EB),
        .INV_EXP  (8'd143)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .rc_idx    (rc_idx),
        .rc        (rc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pw(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % M;
        return r;
    endfunction

    // forward MiMC-7: x <- (x + k + c_i)^7, output x + k
    function automatic int enc(input int p, input int k);
        int x;
        x = p;
        for (int i = 0; i < R; i++) x = pw((x + k + rom[i]) % M, 7);
        return (x + k) % M;
    endfunction

    // inverse by exhaustive search over the field
    function automatic int dec_bf(input int c, input int k);
        for (int p = 0; p < M; p++) begin
            if (enc(p, k) == c) return p;
        end
        return -1;
    endfunction

    function automatic bit is_bad(input int c, input int k);
        return (c >= M) || (k >= M);
    endfunction

    // transaction-level model: 0 idle, 1 working, 2 result held
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1;
                m_k     <= 0;
                m_err   <= is_bad(int'(ct), int'(key));
                m_lat   <= is_bad(int'(ct), int'(key)) ? 1 : LAT;
                m_pt    <= is_bad(int'(ct), int'(key)) ? 0 : dec_bf(int'(ct), int'(key));
            end
        end else if (m_phase == 1) begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_lat) m_phase <= 2;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    // ROM: real constants only in the round's subtract cycle, noise otherwise
    initial rc = 8'd0;
    always @(posedge clk) begin
        #1;
        if (m_phase == 1 && !m_err && m_k > 0 && (m_k % SUBP) == 0)
            rc = 8'(rom[rc_idx]);
        else
            rc = 8'($urandom);
    end

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", int'(out_valid), int'(m_phase == 2));
            chk("in_ready", int'(in_ready), int'(m_phase == 0));
            chk("busy", int'(busy), int'(m_phase != 0));
            if (m_phase == 2) begin
                chk("pt", int'(pt), m_pt);
                chk("err", int'(err), int'(m_err));
            end
            if (m_phase == 1 && !m_err) begin
                chk("rc_idx", int'(rc_idx),
                    (m_k == 0) ? R - 1 : R - 1 - (m_k - 1) / SUBP);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c_, input int k_);
        int i;
        in_valid = 1'b1;
        ct = 8'(c_);
        key = 8'(k_);
        i = 0;
        while (!in_ready && i < 1000) begin
            tick();
            i++;
        end
        chk("send_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        chk("out_seen", int'(out_valid), 1);
        if (!out_valid) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
    endtask

    task automatic take(input int hold);
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ct = '0;
        key = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pt", int'(pt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rc_idx", int'(rc_idx), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        chk("model_enc", enc(3, 5), 240);
        chk("model_root", pw(pw(100, 7), 143), 100);
        chk("model_dec", dec_bf(240, 5), 3);

        // nominal vector with rc_idx boundaries
        tick();
        send(240, 5);
        n = 0;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
            if (n == 145) chk("rc_r0_end", int'(rc_idx), 2);
            if (n == 146) chk("rc_r1_start", int'(rc_idx), 1);
            if (n == 290) chk("rc_r1_end", int'(rc_idx), 1);
            if (n == 291) chk("rc_r2_start", int'(rc_idx), 0);
        end
        chk("lat_nominal", n, 436);
        chk("pt_nominal", int'(pt), 3);
        chk("err_nominal", int'(err), 0);
        take(0);

        // non-canonical inputs
        send(251, 5);
        wait_out(n);
        chk("lat_bad_ct", n, 1);
        chk("err_bad_ct", int'(err), 1);
        chk("pt_bad_ct", int'(pt), 0);
        take(2);
        send(5, 255);
        wait_out(n);
        chk("lat_bad_key", n, 1);
        chk("err_bad_key", int'(err), 1);
        take(0);

        // all-zero input
        send(0, 0);
        wait_out(n);
        chk("lat_zero", n, LAT);
        chk("err_zero", int'(err), 0);
        take(1);

        // backpressure with an ignored request
        send(240, 5);
        wait_out(n);
        in_valid = 1'b1;
        ct = 8'd7;
        key = 8'd9;
        repeat (50) begin
            tick();
            chk("bp_pt", int'(pt), 3);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ready", int'(in_ready), 1);
        chk("bp_release_valid", int'(out_valid), 0);

        // reset in the middle of an exponentiation
        tick();
        send(240, 5);
        repeat (200) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(out_valid), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_rc_idx", int'(rc_idx), 0);
        send(240, 5);
        wait_out(n);
        chk("lat_after_abort", n, 436);
        chk("pt_after_abort", int'(pt), 3);
        take(0);

        // random plaintexts through the forward model
        for (int v = 0; v < 14; v++) begin
            int p_;
            int k_;
            int c_;
            bit bad;
            bad = ($urandom % 5) == 0;
            k_ = int'($urandom_range(0, M - 1));
            p_ = int'($urandom_range(0, M - 1));
            c_ = bad ? int'($urandom_range(M, 255)) : enc(p_, k_);
            send(c_, k_);
            wait_out(n);
            chk("rnd_lat", n, bad ? 1 : LAT);
            chk("rnd_err", int'(err), int'(bad));
            chk("rnd_pt", int'(pt), bad ? 0 : p_);
            take(int'($urandom_range(0, 4)));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mimc_decipher_seq.md
Name: mimc_decipher_seq

Overview:
- Iterative MiMC-7 decryption engine. It inverts the MiMC block cipher used by the hash path: x_{i+1} = (x_i + k + c_i)^7 mod p, with output = x_ROUNDS + k.
- Each round computes the 7th root as y = x^INV_EXP mod p, using constant-time square-and-always-multiply on one internal bit-serial modular multiplier.
- It sits beside the pipelined cipher. Its uses are the ciphertext-recovery/self-check path and bench cross-checking of the encrypt direction.
- Round constants come from the shared constant ROM through an index/data port pair.

Parameters:
- N_BITS, 254, field element width.
- ROUNDS, 91, number of cipher rounds.
- MODULUS, BN254 scalar r (21888242871839275222246405745257275088548364400416034343698204186575808495617), field prime p.
- INV_EXP, 7^-1 mod (MODULUS-1) taken from the project field-constants include, root exponent.
- EXP_BITS, 254, bits of INV_EXP scanned MSB-first.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, ct/key valid.
- in_ready, input→output, 1: output; high only in IDLE.
- ct, input, N_BITS, ciphertext.
- key, input, N_BITS, cipher key.
- rc_idx, output, clog2(ROUNDS), round-constant index to ROM.
- rc, input, N_BITS, round constant c[rc_idx], combinational from ROM, same cycle.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- pt, output, N_BITS, recovered plaintext.
- err, output, 1, non-canonical input flag, qualified by out_valid.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - out_valid=0, pt=0, err=0, busy=0, rc_idx=0, in_ready=1 once rst deasserts.
  - Reset mid-operation aborts with no output.
- Accept: in_valid & in_ready on a clk edge latches ct and key. No further accept until the result handshake completes; there is no overlap.
- Range check at accept: if ct>=MODULUS or key>=MODULUS, go to DONE on the next cycle with err=1 and pt=0.
- States:
  - IDLE -> LOAD: on accept.
  - LOAD: 1 cycle. x = (ct - k) mod p; r = ROUNDS-1; goes to EXP.
  - EXP: y=1 initially. For each bit b of INV_EXP (bit EXP_BITS-1 down to 0):
    - SQ: y=y*y.
    - MUL: t=y*x, and y=t only if b=1.
    - t is always computed, so timing is constant.
  - SUB: 1 cycle. x = (y - k - rc) mod p, with rc sampled this cycle.
    - If r==0, go to DONE.
    - Else r=r-1 and go back to EXP.
  - DONE: out_valid=1, with pt and err stable until out_valid & out_ready. Then go to IDLE; in_ready is high the next cycle.
- rc_idx equals r from LOAD through SUB of each round. It is constant within a round and counts ROUNDS-1 down to 0.
- Modular multiply:
  - Interleaved bit-serial, MSB-first: acc = 2*acc + bit*a, followed by up to two conditional subtractions of p.
  - Internal width N_BITS+2.
  - Takes N_BITS+1 cycles (1 load + N_BITS steps).
  - Operands are < p, and the result is canonical (< p).
- Subtraction: each subtraction that borrows adds p back once, so results stay in [0,p).
- Latency from accept edge to out_valid high: 1 + ROUNDS*(2*EXP_BITS*(N_BITS+1) + 1) cycles. This is independent of data.
  - Error path: 1 cycle.
- Output hold: out_valid stays high indefinitely while out_ready=0. out_ready is ignored when out_valid=0.
- in_valid while busy is ignored, and the input is not latched.

Test Plan:
- Small config (N_BITS=8, ROUNDS=3, MODULUS=251, INV_EXP=143, EXP_BITS=8, ROM c={0,10,20}); ct=240, key=5 -> pt=3, err=0, out_valid exactly 436 cycles after accept.
- Same config; observe rc_idx -> holds 2, then 1, then 0, each for 145 cycles; ROM value sampled only in SUB.
- Same config; ct=251 (>=p), key=5 -> out_valid 1 cycle after accept, err=1, pt=0; ct=0, key=0 -> err=0, valid result in 436 cycles.
- Backpressure: hold out_ready=0 for 50 cycles after out_valid -> pt=3 stable, in_ready=0, second in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
- Reset mid-EXP (cycle 200) -> out_valid=0, busy=0 immediately; new ct=240, key=5 -> pt=3 at 436 cycles.
- Default BN254 config: random pt/key encrypted by the existing cipher model, ciphertext fed in -> pt matches original; 20 vectors, latency per formula.
